// File: rtl/layer_if.sv
// Handshake bundle for one fully connected neural layer: forward argument/result
// streams, backward error/propagate streams, and the train qualifier.
interface layer_if #(
    parameter int N = 2,
    parameter int M = 2,
    parameter int W = 8
);
    logic                      train;
    logic                      argument_valid;
    logic                      argument_ready;
    logic [N-1:0][W-1:0]       argument_data;
    logic                      result_valid;
    logic                      result_ready;
    logic [M-1:0][2*W-1:0]     result_data;
    logic                      error_valid;
    logic                      error_ready;
    logic [M-1:0][2*W-1:0]     error_data;
    logic                      propagate_valid;
    logic                      propagate_ready;
    logic [N-1:0][2*W-1:0]     propagate_data;

    modport master (
        output train,
        output argument_valid, input  argument_ready, output argument_data,
        input  result_valid,   output result_ready,   input  result_data,
        output error_valid,    input  error_ready,    output error_data,
        input  propagate_valid, output propagate_ready, input propagate_data
    );

    modport slave (
        input  train,
        input  argument_valid, output argument_ready, input  argument_data,
        output result_valid,   input  result_ready,   output result_data,
        input  error_valid,    output error_ready,    input  error_data,
        output propagate_valid, input  propagate_ready, output propagate_data
    );
endinterface

// File: rtl/layer.sv
// Fully connected layer with one shared multiply-accumulate: forward pass,
// back-propagation of error and optional saturating weight/bias training.
module layer #(
    parameter int N      = 2,
    parameter int M      = 2,
    parameter int W      = 8,
    parameter int S      = 2,
    parameter int SEED   = 0,
    parameter int RANDOM = 1
) (
    input logic   clock,
    input logic   reset,
    layer_if.slave bus
);
    localparam int ACC_W = 4 * W + $clog2(N + M) + 2;
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int MW    = (M > 1) ? $clog2(M) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [MW-1:0] M_LAST = MW'(M - 1);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef enum logic [2:0] {IDLE, FWD, RES, BWD, PRP} state_t;

    localparam acc_t SAT_MAX = (acc_t'(1) <<< (2 * W - 1)) - acc_t'(1);
    localparam acc_t SAT_MIN = -(acc_t'(1) <<< (2 * W - 1));

    function automatic logic [M-1:0][N-1:0][2*W-1:0] init_weights();
        logic [31:0] x;
        logic [M-1:0][N-1:0][2*W-1:0] t;
        x = 32'(SEED) ^ 32'h2545F491;
        t = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                x = x ^ (x << 13);
                x = x ^ (x >> 17);
                x = x ^ (x << 5);
                t[m][n] = {{W{x[W-1]}}, x[W-1:0]};
            end
        end
        return t;
    endfunction

    localparam logic [M-1:0][N-1:0][2*W-1:0] W_INIT = (RANDOM != 0) ? init_weights() : '0;

    function automatic logic [2*W-1:0] sat(input acc_t v);
        if (v > SAT_MAX) return SAT_MAX[2*W-1:0];
        if (v < SAT_MIN) return SAT_MIN[2*W-1:0];
        return v[2*W-1:0];
    endfunction

    function automatic acc_t widen(input logic signed [2*W-1:0] v);
        return acc_t'(v);
    endfunction

    state_t state, state_next;
    logic   up, have_arg, train_q, flush;
    logic [MW-1:0] m_cnt;
    logic [NW-1:0] n_cnt;
    acc_t   acc, acc_next, w_ext, a_ext, e_ext;
    logic [2*W-1:0]            w_upd;
    logic [N-1:0][W-1:0]       arg_q;
    logic [M-1:0][2*W-1:0]     err_q, result_q, bias_q;
    logic [N-1:0][2*W-1:0]     propagate_q;
    logic [M-1:0][N-1:0][2*W-1:0] weight_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path through the comb block infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.argument_valid && bus.argument_ready)  state_next = FWD;
                  else if (bus.error_valid && bus.error_ready)   state_next = BWD;
            FWD:  if (flush)               state_next = RES;
            RES:  if (bus.result_ready)    state_next = IDLE;
            BWD:  if (flush)               state_next = PRP;
            PRP:  if (bus.propagate_ready) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.argument_ready  = (state == IDLE) && up;
        bus.error_ready     = (state == IDLE) && up && have_arg && !bus.argument_valid;
        bus.result_valid    = (state == RES);
        bus.propagate_valid = (state == PRP);
        bus.result_data     = result_q;
        bus.propagate_data  = propagate_q;
    end

    // Forward walks (m outer, n inner); backward walks (n outer, m inner) so one
    // accumulator builds each propagate term while each weight is read once before update.
    always_comb begin
        w_ext    = widen(weight_q[m_cnt][n_cnt]);
        a_ext    = acc_t'(arg_q[n_cnt]);
        e_ext    = widen(err_q[m_cnt]);
        acc_next = acc + w_ext * ((state == BWD) ? e_ext : a_ext);
        w_upd    = sat(w_ext + ((e_ext * a_ext) >>> (W + S)));
    end

    // NOTE: weights and biases are reset explicitly; they are registers with defined
    // power-on contents, not a RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up          <= 1'b0;
            have_arg    <= 1'b0;
            train_q     <= 1'b0;
            flush       <= 1'b0;
            m_cnt       <= '0;
            n_cnt       <= '0;
            acc         <= '0;
            arg_q       <= '0;
            err_q       <= '0;
            result_q    <= '0;
            propagate_q <= '0;
            bias_q      <= '0;
            weight_q    <= W_INIT;
        end else begin
            up <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.argument_valid && bus.argument_ready) begin
                        arg_q    <= bus.argument_data;
                        have_arg <= 1'b1;
                        m_cnt    <= '0;
                        n_cnt    <= '0;
                        acc      <= widen(bias_q[0]) <<< W;
                    end else if (bus.error_valid && bus.error_ready) begin
                        err_q   <= bus.error_data;
                        train_q <= bus.train;
                        m_cnt   <= '0;
                        n_cnt   <= '0;
                        acc     <= '0;
                    end
                end
                FWD: begin
                    if (flush) begin
                        flush <= 1'b0;
                    end else if (n_cnt == N_LAST) begin
                        result_q[m_cnt] <= sat(acc_next >>> W);
                        n_cnt <= '0;
                        if (m_cnt == M_LAST) begin
                            flush <= 1'b1;
                        end else begin
                            m_cnt <= m_cnt + 1'b1;
                            acc   <= widen(bias_q[m_cnt + 1'b1]) <<< W;
                        end
                    end else begin
                        n_cnt <= n_cnt + 1'b1;
                        acc   <= acc_next;
                    end
                end
                BWD: begin
                    if (flush) begin
                        flush <= 1'b0;
                        if (train_q) begin
                            for (int m = 0; m < M; m++)
                                bias_q[m] <= sat(widen(bias_q[m]) + (widen(err_q[m]) >>> S));
                        end
                    end else begin
                        if (train_q) weight_q[m_cnt][n_cnt] <= w_upd;
                        if (m_cnt == M_LAST) begin
                            propagate_q[n_cnt] <= sat(acc_next >>> W);
                            m_cnt <= '0;
                            acc   <= '0;
                            if (n_cnt == N_LAST) flush <= 1'b1;
                            else                 n_cnt <= n_cnt + 1'b1;
                        end else begin
                            m_cnt <= m_cnt + 1'b1;
                            acc   <= acc_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer.sv
// Self-checking bench for layer: a behavioural model feeds result/propagate
// scoreboards that are drained as the DUT presents each output.
module tb_layer;
    localparam int N = 2;
    localparam int M = 2;
    localparam int W = 8;
    localparam int S = 2;
    localparam longint SMAX = (longint'(1) << (2 * W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (2 * W - 1));

    typedef logic [N-1:0][W-1:0]   avec_t;
    typedef logic [M-1:0][2*W-1:0] rvec_t;
    typedef logic [N-1:0][2*W-1:0] pvec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    layer_if #(.N(N), .M(M), .W(W)) bus ();

    layer #(.N(N), .M(M), .W(W), .S(S), .SEED(0), .RANDOM(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_err    = 0;
    int n_checks = 0;

    longint mw [M][N];
    longint mb [M];
    longint marg [N];
    rvec_t  res_q [$];
    pvec_t  prp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            mb[m] = 0;
            for (int n = 0; n < N; n++) mw[m][n] = 0;
        end
        for (int n = 0; n < N; n++) marg[n] = 0;
        res_q.delete();
        prp_q.delete();
    endtask

    task automatic send_arg(input avec_t a);
        rvec_t  e;
        longint s;
        int     t;
        for (int n = 0; n < N; n++) marg[n] = longint'(a[n]);
        for (int m = 0; m < M; m++) begin
            s = mb[m] * (longint'(1) << W);
            for (int n = 0; n < N; n++) s += mw[m][n] * marg[n];
            e[m] = (2*W)'(sat(s >>> W));
        end
        res_q.push_back(e);
        bus.argument_data  = a;
        bus.argument_valid = 1'b1;
        t = 0;
        while (!bus.argument_ready && t < 50) begin
            tick();
            t++;
        end
        check("arg_accept", bus.argument_ready, 1);
        tick();
        bus.argument_valid = 1'b0;
    endtask

    task automatic send_err(input rvec_t e, input logic tr);
        pvec_t  p;
        longint ev [M];
        longint s;
        int     t;
        for (int m = 0; m < M; m++) ev[m] = longint'($signed(e[m]));
        for (int n = 0; n < N; n++) begin
            s = 0;
            for (int m = 0; m < M; m++) s += mw[m][n] * ev[m];
            p[n] = (2*W)'(sat(s >>> W));
        end
        if (tr) begin
            for (int m = 0; m < M; m++) begin
                for (int n = 0; n < N; n++)
                    mw[m][n] = sat(mw[m][n] + ((ev[m] * marg[n]) >>> (W + S)));
                mb[m] = sat(mb[m] + (ev[m] >>> S));
            end
        end
        prp_q.push_back(p);
        bus.error_data  = e;
        bus.error_valid = 1'b1;
        bus.train       = tr;
        t = 0;
        while (!bus.error_ready && t < 50) begin
            tick();
            t++;
        end
        check("err_accept", bus.error_ready, 1);
        tick();
        bus.error_valid = 1'b0;
        // Flip train mid-pass; the layer must keep the value sampled at the transfer.
        bus.train = ~tr;
    endtask

    task automatic get_result(input int hold);
        int    lat;
        rvec_t exp;
        lat = 0;
        while (!bus.result_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("fwd_latency", lat, N * M + 1);
        if (res_q.size() == 0) begin
            check("res_queue_empty", 1, 0);
            exp = 'x;
        end else begin
            exp = res_q.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            check("hold_arg_ready", bus.argument_ready, 0);
            check("hold_result", bus.result_data, exp);
            tick();
        end
        check("result", bus.result_data, exp);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("res_valid_drop", bus.result_valid, 0);
    endtask

    task automatic get_prop();
        int    lat;
        pvec_t exp;
        lat = 0;
        while (!bus.propagate_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bwd_latency", lat, N * M + 1);
        if (prp_q.size() == 0) begin
            check("prp_queue_empty", 1, 0);
            exp = 'x;
        end else begin
            exp = prp_q.pop_front();
        end
        check("propagate", bus.propagate_data, exp);
        bus.propagate_ready = 1'b1;
        tick();
        bus.propagate_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        avec_t ff_arg, zero_arg, ra;
        rvec_t one_err, max_err, re;
        ff_arg   = {8'hff, 8'hff};
        zero_arg = '0;
        one_err  = {16'h0100, 16'h0100};
        max_err  = {16'h7fff, 16'h7fff};

        reset = 1'b1;
        bus.train = 1'b0;
        bus.argument_valid = 1'b0;
        bus.argument_data = '0;
        bus.result_ready = 1'b0;
        bus.error_valid = 1'b0;
        bus.error_data = '0;
        bus.propagate_ready = 1'b0;
        model_reset();
        tick();
        tick();
        check("in_reset_arg_ready", bus.argument_ready, 0);
        reset = 1'b0;
        tick();
        check("rst_arg_ready", bus.argument_ready, 1);
        check("rst_err_ready", bus.error_ready, 0);
        check("rst_res_valid", bus.result_valid, 0);
        check("rst_prp_valid", bus.propagate_valid, 0);

        // Untrained forward, one training step, then pure back-propagation.
        send_arg(ff_arg);  get_result(0);
        send_err(one_err, 1'b1); get_prop();
        send_arg(ff_arg);  get_result(0);
        send_err(one_err, 1'b0); get_prop();
        send_arg(ff_arg);  get_result(10);

        // Argument wins over a simultaneously offered error.
        bus.error_data     = one_err;
        bus.error_valid    = 1'b1;
        bus.train          = 1'b0;
        bus.argument_data  = ff_arg;
        bus.argument_valid = 1'b1;
        #1;
        check("prio_err_ready", bus.error_ready, 0);
        check("prio_arg_ready", bus.argument_ready, 1);
        send_arg(ff_arg);
        check("prio_err_blocked", bus.error_ready, 0);
        get_result(0);
        send_err(one_err, 1'b0); get_prop();

        // Bias saturation from a fresh reset.
        reset = 1'b1;
        #1;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        send_arg(zero_arg); get_result(0);
        for (int i = 0; i < 5; i++) begin
            send_err(max_err, 1'b1); get_prop();
            send_arg(zero_arg); get_result(0);
        end

        // Reset landing in the middle of a backward pass.
        send_arg(ff_arg); get_result(0);
        send_err(one_err, 1'b1); get_prop();
        send_err(one_err, 1'b1);
        tick();
        check("bwd_prp_valid", bus.propagate_valid, 0);
        check("bwd_arg_ready", bus.argument_ready, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_res_valid", bus.result_valid, 0);
        check("mid_rst_prp_valid", bus.propagate_valid, 0);
        check("mid_rst_err_ready", bus.error_ready, 0);
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_arg_ready", bus.argument_ready, 1);
        send_arg(ff_arg); get_result(0);

        // Random traffic with mixed training.
        for (int i = 0; i < 8; i++) begin
            ra = avec_t'($urandom);
            send_arg(ra);
            get_result(int'($urandom_range(0, 2)));
            re = rvec_t'($urandom);
            send_err(re, 1'($urandom_range(0, 1)));
            get_prop();
        end
        send_arg(ff_arg); get_result(0);

        check("scoreboard_drained", 64'(res_q.size() + prp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
